// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : Requester handshake and transmitter launch bundle for the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           txData;
    logic                 txStart;
    logic [ID_W-1:0]      gnt_id;
    logic                 busy;
    logic [15:0]          frames_sent;

    modport master (
        output req_valid, req_data,
        input  req_ready, txData, txStart, gnt_id, busy, frames_sent
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, txData, txStart, gnt_id, busy, frames_sent
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one UART transmitter; one launch per frame window.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CLOCKS_PER_BIT = 87,
    parameter int GAP_CLKS       = 2
) (
    input  wire logic        clkTx,
    input  wire logic        resetreg,
    uart_tx_arbiter_if.slave bus
);
    localparam int FRAME_CLKS = 10 * CLOCKS_PER_BIT + GAP_CLKS;
    localparam int CNT_W      = $clog2(FRAME_CLKS + 1);
    localparam int ID_W       = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CLKS - 1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   frame_cnt;
    logic [7:0]         tx_data;
    logic [ID_W-1:0]    gnt;
    logic [15:0]        frame_total;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W:0]      cand_sum;
    logic [ID_W-1:0]    rr_nxt;
    logic [NUM_REQ-1:0] ready_vec;
    logic               accept;

    // Search upward from rr_ptr; rr_ptr and k are both below NUM_REQ, so one
    // conditional subtract is enough to wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand_sum >= NUM_REQ_W) begin
                cand_sum = cand_sum - NUM_REQ_W;
            end
            if (!win_found && bus.req_valid[cand_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        rr_nxt = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
    end

    assign accept = (state == IDLE) && win_found;

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec = NUM_REQ'(1) << win_id;
        end
    end

    always_ff @(posedge clkTx or posedge resetreg) begin
        if (resetreg) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = START;
            START:   state_nxt = FRAME;
            FRAME:   if (frame_cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // txData/gnt only load on acceptance, so they stay put for the whole window.
    always_ff @(posedge clkTx or posedge resetreg) begin
        if (resetreg) begin
            rr_ptr      <= '0;
            tx_data     <= '0;
            gnt         <= '0;
            frame_cnt   <= '0;
            frame_total <= '0;
        end else begin
            if (accept) begin
                tx_data <= bus.req_data[{win_id, 3'b000} +: 8];
                gnt     <= win_id;
                rr_ptr  <= rr_nxt;
            end
            if (state == START) begin
                frame_total <= frame_total + 16'd1;
                frame_cnt   <= '0;
            end else if (state == FRAME) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready   = ready_vec;
    assign bus.txData      = tx_data;
    assign bus.txStart     = (state == START);
    assign bus.gnt_id      = gnt;
    assign bus.busy        = (state != IDLE);
    assign bus.frames_sent = frame_total;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Scoreboard bench: a round-robin reference model predicts launches.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int FRAME = 10 * 87 + 2;

    localparam int M_DROP   = 0;
    localparam int M_HOLD   = 1;
    localparam int M_STREAM = 2;
    localparam int M_RAND   = 3;

    typedef struct {
        logic [7:0] data;
        int         id;
        int         edge_n;
    } launch_t;

    logic         clkTx    = 1'b0;
    logic         resetreg = 1'b1;
    logic [N-1:0] vld      = '0;
    logic [7:0]   dat [N];

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    assign bus.req_valid = vld;
    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < N; i++) bus.req_data[i*8 +: 8] = dat[i];
    end

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .CLOCKS_PER_BIT(87),
        .GAP_CLKS      (2)
    ) dut (
        .clkTx   (clkTx),
        .resetreg(resetreg),
        .bus     (bus)
    );

    initial forever #5 clkTx = ~clkTx;

    int checks = 0;
    int errors = 0;

    int           cyc        = 0;
    int           m_rr       = 0;
    int           m_free_at  = 0;
    int           m_last_acc = -100000;
    int           m_win;
    logic [N-1:0] acc_mask   = '0;
    launch_t      exp_q[$];

    logic [7:0]   launch_log[$];
    int           id_log[$];
    int           cyc_log[$];

    int           mode        = M_DROP;
    int           stream_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference model: one acceptance per window, earliest FRAME+2 edges after
    // the previous one, winner chosen round-robin from the pointer.
    initial begin
        forever begin
            @(posedge clkTx);
            cyc++;
            acc_mask = '0;
            if (resetreg) begin
                m_rr       = 0;
                m_free_at  = 0;
                m_last_acc = -100000;
                exp_q.delete();
            end else if (cyc >= m_free_at && vld != '0) begin
                m_win = rr_pick(vld, m_rr);
                exp_q.push_back('{data: dat[m_win], id: m_win, edge_n: cyc});
                m_rr            = (m_win + 1) % N;
                m_free_at       = cyc + FRAME + 2;
                m_last_acc      = cyc;
                acc_mask[m_win] = 1'b1;
            end
        end
    end

    int           exp_frames = 0;
    logic [7:0]   hold_data  = '0;
    int           hold_id    = 0;
    logic         hold_valid = 1'b0;
    logic [N-1:0] exp_rdy;
    int           mon_w;
    launch_t      got;

    initial begin
        forever begin
            @(negedge clkTx);
            if (resetreg) begin
                exp_frames = 0;
                hold_valid = 1'b0;
            end else begin
                check("busy", 32'(bus.busy),
                      32'((cyc - m_last_acc) >= 0 && (cyc - m_last_acc) <= FRAME));
                exp_rdy = '0;
                if (cyc + 1 >= m_free_at && vld != '0) begin
                    mon_w          = rr_pick(vld, m_rr);
                    exp_rdy[mon_w] = 1'b1;
                end
                check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
                if (bus.txStart) begin
                    launch_log.push_back(bus.txData);
                    id_log.push_back(int'(bus.gnt_id));
                    cyc_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check("txStart_unexpected", 32'(bus.txStart), 32'd0);
                    end else begin
                        got = exp_q.pop_front();
                        check("txData", 32'(bus.txData), 32'(got.data));
                        check("gnt_id", 32'(bus.gnt_id), 32'(got.id));
                        check("launch_edge", 32'(cyc), 32'(got.edge_n));
                        check("frames_sent_at_start", 32'(bus.frames_sent), 32'(exp_frames));
                        hold_data  = got.data;
                        hold_id    = got.id;
                        hold_valid = 1'b1;
                    end
                    exp_frames = (exp_frames + 1) & 32'hFFFF;
                end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
                    check("txStart_missing", 32'(bus.txStart), 32'd1);
                    void'(exp_q.pop_front());
                end else if (bus.busy && hold_valid) begin
                    check("txData_hold", 32'(bus.txData), 32'(hold_data));
                    check("gnt_id_hold", 32'(bus.gnt_id), 32'(hold_id));
                end
            end
        end
    end

    task automatic step();
        @(posedge clkTx);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                case (mode)
                    M_DROP:   vld[i] = 1'b0;
                    M_STREAM: begin
                        if (stream_left > 1) begin
                            dat[i] = dat[i] + 8'd1;
                            stream_left--;
                        end else begin
                            vld[i]      = 1'b0;
                            stream_left = 0;
                        end
                    end
                    M_RAND: begin
                        vld[i] = 1'($urandom_range(0, 1));
                        dat[i] = 8'($urandom);
                    end
                    default: ;
                endcase
            end else if (mode == M_RAND) begin
                if (!vld[i] && $urandom_range(0, 99) < 3) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end else if (vld[i] && $urandom_range(0, 1999) == 0) begin
                    vld[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_launches(input int n);
        int b = 0;
        while (launch_log.size() < n && b < (n + 2) * (FRAME + 4)) begin
            step();
            b++;
        end
        check("launch_count", 32'(launch_log.size()), 32'(n));
    endtask

    task automatic drain();
        int b = 0;
        while ((bus.busy || vld != '0) && b < 4 * FRAME) begin
            step();
            b++;
        end
        check("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clkTx);
        #1;
        resetreg = 1'b1;
        vld      = '0;
        repeat (2) @(posedge clkTx);
        #1;
        resetreg = 1'b0;
        launch_log.delete();
        id_log.delete();
        cyc_log.delete();
    endtask

    task automatic check_log(input string name, input logic [7:0] eb[$], input int ei[$]);
        check({name, "_len"}, 32'(launch_log.size()), 32'(eb.size()));
        for (int i = 0; i < eb.size(); i++) begin
            if (i < launch_log.size()) begin
                check({name, "_data"}, 32'(launch_log[i]), 32'(eb[i]));
                check({name, "_id"}, 32'(id_log[i]), 32'(ei[i]));
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] eb[$];
    int         ei[$];
    int         cyc_d;

    initial begin
        for (int i = 0; i < N; i++) dat[i] = 8'h00;
        repeat (3) @(posedge clkTx);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_txStart", 32'(bus.txStart), 32'd0);
        check("rst_txData", 32'(bus.txData), 32'd0);
        check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        check("rst_frames", 32'(bus.frames_sent), 32'd0);
        resetreg = 1'b0;

        // Single request
        mode   = M_DROP;
        dat[0] = 8'hA5;
        vld    = 4'b0001;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'h1);
        wait_launches(1);
        drain();
        eb = '{8'hA5};
        ei = '{0};
        check_log("single", eb, ei);
        check("single_frames", 32'(bus.frames_sent), 32'd1);

        // Fairness with all four held
        do_reset();
        mode = M_HOLD;
        dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
        vld  = 4'b1111;
        wait_launches(5);
        vld = '0;
        drain();
        eb = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        ei = '{0, 1, 2, 3, 0};
        check_log("fair", eb, ei);
        for (int i = 1; i < cyc_log.size(); i++) begin
            check("fair_spacing", 32'(cyc_log[i] - cyc_log[i-1]), 32'd874);
        end

        // Pointer wrap
        do_reset();
        mode   = M_DROP;
        dat[3] = 8'h3C;
        vld    = 4'b1000;
        wait_launches(1);
        dat[0] = 8'h0A;
        vld    = 4'b1001;
        wait_launches(3);
        drain();
        eb = '{8'h3C, 8'h0A, 8'h3C};
        ei = '{3, 0, 3};
        check_log("wrap", eb, ei);

        // Back-to-back stream from requester 2
        do_reset();
        mode        = M_STREAM;
        dat[2]      = 8'h00;
        stream_left = 5;
        vld         = 4'b0100;
        wait_launches(5);
        drain();
        repeat (FRAME + 10) step();
        eb = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        ei = '{2, 2, 2, 2, 2};
        check_log("stream", eb, ei);
        check("stream_frames", 32'(bus.frames_sent), 32'd5);

        // Reset mid-frame with a pending request
        do_reset();
        mode   = M_DROP;
        dat[0] = 8'h77;
        vld    = 4'b0001;
        wait_launches(1);
        repeat (300) step();
        dat[2] = 8'h5B;
        vld    = 4'b0100;
        resetreg = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_txStart", 32'(bus.txStart), 32'd0);
        check("mid_rst_txData", 32'(bus.txData), 32'd0);
        check("mid_rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        check("mid_rst_frames", 32'(bus.frames_sent), 32'd0);
        repeat (2) @(posedge clkTx);
        #1;
        resetreg = 1'b0;
        cyc_d    = cyc;
        launch_log.delete();
        id_log.delete();
        cyc_log.delete();
        wait_launches(1);
        drain();
        eb = '{8'h5B};
        ei = '{2};
        check_log("post_rst", eb, ei);
        if (cyc_log.size() > 0) check("post_rst_edge", 32'(cyc_log[0]), 32'(cyc_d + 1));

        // Withdrawal during FRAME produces no launch
        do_reset();
        mode   = M_DROP;
        dat[1] = 8'h66;
        vld    = 4'b0010;
        wait_launches(1);
        repeat (100) step();
        dat[0] = 8'h99;
        vld[0] = 1'b1;
        repeat (100) step();
        vld[0] = 1'b0;
        drain();
        repeat (FRAME + 10) step();
        eb = '{8'h66};
        ei = '{1};
        check_log("withdraw", eb, ei);

        // Randomised traffic
        mode = M_RAND;
        repeat (30000) step();
        mode = M_DROP;
        vld  = '0;
        drain();
        repeat (5) step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
